// File: rtl/postfix_evaluator.sv
`timescale 1ns/1ps
// postfix_evaluator: steps a selectable postfix code program, fetches leaf
// values through the operand-decoder handshake, dispatches operators to the
// shared FP ALU and keeps intermediates on an internal register stack.
// Optional feature macro: POSTFIX_EVAL_TIMEOUT_EN (16-bit watchdog on the
// OPND / ALU_WAIT states, reports error_code 2'b11 when it expires).
//
// Handshakes: opnd_req and alu_start are single-cycle request pulses; the
// matching opnd_valid / alu_done pulse is consumed only while the FSM sits in
// OPND / ALU_WAIT respectively, and is ignored in every other state.
// opnd_code, operand_a, operand_b and alu_op stay stable until consumed.
module postfix_evaluator #(
  parameter int DATA_WIDTH      = 32,
  parameter int CODE_WIDTH      = 8,
  parameter int NUM_EXPR        = 4,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int STACK_DEPTH     = 16,
  localparam int SEL_W = (NUM_EXPR > 1) ? $clog2(NUM_EXPR) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SEL_W-1:0]           expr_sel,
  output logic                       busy,
  output logic [SEL_W-1:0]           prog_sel,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  input  logic [CODE_WIDTH-1:0]      prog_data,
  output logic                       opnd_req,
  output logic [CODE_WIDTH-1:0]      opnd_code,
  input  logic                       opnd_valid,
  input  logic [DATA_WIDTH-1:0]      opnd_data,
  output logic                       alu_start,
  output logic [2:0]                 alu_op,
  output logic [DATA_WIDTH-1:0]      operand_a,
  output logic [DATA_WIDTH-1:0]      operand_b,
  input  logic                       alu_done,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  output logic [DATA_WIDTH-1:0]      result,
  output logic                       result_valid,
  output logic                       error,
  output logic [1:0]                 error_code,
  output logic [3:0]                 dbg_state
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_ROMWAIT   = 4'd2;
  localparam logic [3:0] S_DECODE    = 4'd3;
  localparam logic [3:0] S_OPND      = 4'd4;
  localparam logic [3:0] S_ALU_ISSUE = 4'd5;
  localparam logic [3:0] S_ALU_WAIT  = 4'd6;
  localparam logic [3:0] S_CHECK     = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ERR       = 4'd9;

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [1:0] ERR_UNDERFLOW = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_BAD_END   = 2'b10;

  logic [3:0]            state;
  logic [SP_W-1:0]       sp;
  logic [DATA_WIDTH-1:0] stack [STACK_DEPTH];
  logic [2:0]            op_q;

`ifdef POSTFIX_EVAL_TIMEOUT_EN
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  logic [15:0] wd;
`endif

  // Stack addressing: push slot, top-of-stack and second-from-top.
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      top_idx;
  logic [IDX_W-1:0]      sec_idx;
  logic [DATA_WIDTH-1:0] top_val;
  assign push_idx = IDX_W'(sp);
  assign top_idx  = IDX_W'(sp - SP_ONE);
  assign sec_idx  = IDX_W'(sp - SP_TWO);
  assign top_val  = stack[top_idx];

  // Code word classification.
  logic is_end, is_op, is_nop, is_sub;
  assign is_end = (prog_data == {CODE_WIDTH{1'b1}});
  assign is_op  = (prog_data[CODE_WIDTH-1:CODE_WIDTH-2] == 2'b10);
  assign is_nop = (prog_data[2:0] > 3'b100);
  assign is_sub = (op_q == 3'b100);

  assign dbg_state = state;

  // Evaluation FSM, stack and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      sp           <= '0;
      op_q         <= '0;
      busy         <= 1'b0;
      prog_sel     <= '0;
      prog_addr    <= '0;
      opnd_req     <= 1'b0;
      opnd_code    <= '0;
      alu_start    <= 1'b0;
      alu_op       <= '0;
      operand_a    <= '0;
      operand_b    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      error_code   <= '0;
`ifdef POSTFIX_EVAL_TIMEOUT_EN
      wd           <= '0;
`endif
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      opnd_req     <= 1'b0;
      alu_start    <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            prog_sel  <= expr_sel;
            prog_addr <= '0;
            sp        <= '0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH:   state <= S_ROMWAIT;
        S_ROMWAIT: state <= S_DECODE;
        S_DECODE: begin
          // Address wraps naturally at the top of the program space.
          prog_addr <= prog_addr + 1'b1;
          if (is_end) begin
            state <= S_CHECK;
          end else if (is_op) begin
            op_q  <= prog_data[2:0];
            state <= is_nop ? S_FETCH : S_ALU_ISSUE;
          end else begin
            opnd_code <= prog_data;
            opnd_req  <= 1'b1;
            state     <= S_OPND;
`ifdef POSTFIX_EVAL_TIMEOUT_EN
            wd        <= '0;
`endif
          end
        end
        S_OPND: begin
          if (opnd_valid) begin
            if (sp == SP_FULL) begin
              error      <= 1'b1;
              error_code <= ERR_OVERFLOW;
              busy       <= 1'b0;
              state      <= S_ERR;
            end else begin
              stack[push_idx] <= opnd_data;
              sp              <= sp + SP_ONE;
              state           <= S_FETCH;
            end
          end
`ifdef POSTFIX_EVAL_TIMEOUT_EN
          else if (wd == 16'hFFFF) begin
            error      <= 1'b1;
            error_code <= ERR_TIMEOUT;
            busy       <= 1'b0;
            state      <= S_ERR;
          end else begin
            wd <= wd + 16'd1;
          end
`endif
        end
        S_ALU_ISSUE: begin
          if (sp < SP_TWO) begin
            error      <= 1'b1;
            error_code <= ERR_UNDERFLOW;
            busy       <= 1'b0;
            state      <= S_ERR;
          end else begin
            // SUB is issued as ADD with the top operand negated.
            operand_a <= stack[sec_idx];
            operand_b <= is_sub ? {~top_val[DATA_WIDTH-1], top_val[DATA_WIDTH-2:0]}
                                : top_val;
            alu_op    <= is_sub ? 3'b011 : op_q;
            alu_start <= 1'b1;
            state     <= S_ALU_WAIT;
`ifdef POSTFIX_EVAL_TIMEOUT_EN
            wd        <= '0;
`endif
          end
        end
        S_ALU_WAIT: begin
          if (alu_done) begin
            // Pop two, push one: the result overwrites the second-from-top.
            stack[sec_idx] <= alu_result;
            sp             <= sp - SP_ONE;
            state          <= S_FETCH;
          end
`ifdef POSTFIX_EVAL_TIMEOUT_EN
          else if (wd == 16'hFFFF) begin
            error      <= 1'b1;
            error_code <= ERR_TIMEOUT;
            busy       <= 1'b0;
            state      <= S_ERR;
          end else begin
            wd <= wd + 16'd1;
          end
`endif
        end
        S_CHECK: begin
          if (sp == SP_ONE) begin
            result       <= stack[0];
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= S_DONE;
          end else begin
            error      <= 1'b1;
            error_code <= ERR_BAD_END;
            busy       <= 1'b0;
            state      <= S_ERR;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_postfix_evaluator.sv
`timescale 1ns/1ps
// Directed bench for postfix_evaluator: code ROM, operand decoder and ALU
// behavioural models, a table of programs with hand-computed outcomes, plus
// hand-written sequences for start-while-busy and reset during ALU_WAIT.
module tb_postfix_evaluator;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic          start = 1'b0;
  logic [2:0]    expr_sel = '0;
  logic          busy;
  logic [2:0]    prog_sel;
  logic [3:0]    prog_addr;
  logic [7:0]    prog_data;
  logic          opnd_req;
  logic [7:0]    opnd_code;
  logic          opnd_valid = 1'b0;
  logic [DW-1:0] opnd_data = '0;
  logic          alu_start;
  logic [2:0]    alu_op;
  logic [DW-1:0] operand_a, operand_b;
  logic          alu_done = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          error;
  logic [1:0]    error_code;
  logic [3:0]    dbg_state;

  postfix_evaluator #(
    .DATA_WIDTH(32), .CODE_WIDTH(8), .NUM_EXPR(8),
    .PROG_ADDR_WIDTH(4), .STACK_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .expr_sel(expr_sel),
    .busy(busy), .prog_sel(prog_sel), .prog_addr(prog_addr), .prog_data(prog_data),
    .opnd_req(opnd_req), .opnd_code(opnd_code), .opnd_valid(opnd_valid),
    .opnd_data(opnd_data), .alu_start(alu_start), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .alu_done(alu_done),
    .alu_result(alu_result), .result(result), .result_valid(result_valid),
    .error(error), .error_code(error_code), .dbg_state(dbg_state)
  );

  // ---------------- environment models ----------------
  logic [7:0]    rom [8][16];
  logic [DW-1:0] lv  [8];
  int dec_lat = 2;
  int alu_lat = 1;
  int dec_cnt = 0;
  int alu_cnt = 0;
  logic [2:0]    dec_code = '0;
  logic [DW-1:0] alu_pend = '0;

  // ALU reference: real FP results for the few pairs used with meaningful
  // values, otherwise a reproducible mix of the operands.
  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (op == 3'b001 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == 3'b011 && a == 32'h40A00000 && b == 32'hC0400000) return 32'h40000000;
    if (op == 3'b011 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ b ^ {29'd0, op};
  endfunction

  always @(posedge clock) prog_data <= rom[prog_sel][prog_addr];

  always @(posedge clock) begin
    opnd_valid <= 1'b0;
    if (dec_cnt > 0) begin
      dec_cnt <= dec_cnt - 1;
      if (dec_cnt == 1) begin
        opnd_valid <= 1'b1;
        opnd_data  <= lv[dec_code];
      end
    end else if (opnd_req) begin
      dec_cnt  <= dec_lat;
      dec_code <= opnd_code[2:0];
    end
  end

  always @(posedge clock) begin
    alu_done <= 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) begin
        alu_done   <= 1'b1;
        alu_result <= alu_pend;
      end
    end else if (alu_start) begin
      alu_cnt  <= alu_lat;
      alu_pend <= alu_fn(alu_op, operand_a, operand_b);
    end
  end

  // ---------------- pulse monitor ----------------
  int rv_cnt = 0, err_cnt = 0, as_cnt = 0, done_cnt = 0;
  logic [DW-1:0] last_result = '0;
  logic [1:0]    last_code = '0;
  logic [2:0]    cap_op = '0;
  logic [DW-1:0] cap_a = '0, cap_b = '0;

  always @(negedge clock) begin
    if (result_valid) begin rv_cnt++; last_result = result; end
    if (error) begin err_cnt++; last_code = error_code; end
    if (alu_start) begin as_cnt++; cap_op = alu_op; cap_a = operand_a; cap_b = operand_b; end
    if (alu_done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  int rv0, er0, as0, dn0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_expr(input logic [2:0] sel, input bit poke, output bit ok);
    int n;
    rv0 = rv_cnt; er0 = err_cnt; as0 = as_cnt;
    @(negedge clock); expr_sel = sel; start = 1'b1;
    @(negedge clock); start = 1'b0;
    if (poke) begin
      repeat (4) @(negedge clock);
      expr_sel = 3'd2; start = 1'b1;
      @(negedge clock); start = 1'b0;
    end
    ok = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(posedge clock);
      if (rv_cnt != rv0 || err_cnt != er0) begin ok = 1'b1; break; end
      n++;
    end
    repeat (4) @(negedge clock);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]    sel;
    bit            is_err;
    logic [DW-1:0] exp_val;
    logic [1:0]    exp_code;
    int            exp_alu;
    string         name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    int n;

    lv[0] = 32'h3F800000; lv[1] = 32'h40000000; lv[2] = 32'h40400000; lv[3] = 32'h40A00000;
    lv[4] = 32'h40800000; lv[5] = 32'h3F000000; lv[6] = 32'h41200000; lv[7] = 32'hBF800000;
    for (int p = 0; p < 8; p++) for (int a = 0; a < 16; a++) rom[p][a] = 8'hFF;
    // 2.0 (const), 3.0 (trig class), MUL, END
    rom[0][0] = 8'h01; rom[0][1] = 8'hC2; rom[0][2] = 8'h81;
    // 5.0, 3.0, SUB, END
    rom[1][0] = 8'h03; rom[1][1] = 8'h02; rom[1][2] = 8'h84;
    // ADD, END -> underflow
    rom[2][0] = 8'h83;
    // five leaves into a 4-deep stack -> overflow
    rom[3][0] = 8'h00; rom[3][1] = 8'h01; rom[3][2] = 8'h02; rom[3][3] = 8'h03; rom[3][4] = 8'h04;
    // 1.0, 2.0 (state-var class), END -> bad end depth
    rom[4][0] = 8'h00; rom[4][1] = 8'h41;
    // 1.0, 2.0, ADD, NOP, 3.0, MUL, END
    rom[5][0] = 8'h00; rom[5][1] = 8'h01; rom[5][2] = 8'h83; rom[5][3] = 8'h85;
    rom[5][4] = 8'h02; rom[5][5] = 8'h81;
    // 4.0, 2.0, DIV, END
    rom[6][0] = 8'h04; rom[6][1] = 8'h01; rom[6][2] = 8'h82;
    // program 7 is a bare END -> bad end depth (sp=0)

    vecs[0] = '{3'd0, 1'b0, 32'h40C00000, 2'b00, 1, "mul_2x3"};
    vecs[1] = '{3'd1, 1'b0, 32'h40000000, 2'b00, 1, "sub_5m3"};
    vecs[2] = '{3'd2, 1'b1, 32'h0,        2'b00, 0, "underflow"};
    vecs[3] = '{3'd3, 1'b1, 32'h0,        2'b01, 0, "overflow"};
    vecs[4] = '{3'd4, 1'b1, 32'h0,        2'b10, 0, "bad_end_2"};
    vecs[5] = '{3'd5, 1'b0, 32'h00000001, 2'b00, 2, "add_nop_mul"};
    vecs[6] = '{3'd6, 1'b0, 32'h00800002, 2'b00, 1, "div"};
    vecs[7] = '{3'd7, 1'b1, 32'h0,        2'b10, 0, "bad_end_0"};

    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", error, 0);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_opnd_req", opnd_req, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Table-driven programs.
    for (int i = 0; i < 8; i++) begin
      alu_lat = 1 + (i % 3);
      run_expr(vecs[i].sel, 1'b0, ok);
      chk({vecs[i].name, "_completed"}, ok, 1);
      chk({vecs[i].name, "_busy_low"}, busy, 0);
      chk({vecs[i].name, "_alu_starts"}, as_cnt - as0, vecs[i].exp_alu);
      if (vecs[i].is_err) begin
        chk({vecs[i].name, "_err_pulses"}, err_cnt - er0, 1);
        chk({vecs[i].name, "_rv_pulses"}, rv_cnt - rv0, 0);
        chk({vecs[i].name, "_err_code"}, last_code, vecs[i].exp_code);
      end else begin
        chk({vecs[i].name, "_rv_pulses"}, rv_cnt - rv0, 1);
        chk({vecs[i].name, "_err_pulses"}, err_cnt - er0, 0);
        chk({vecs[i].name, "_result_pulse"}, last_result, vecs[i].exp_val);
        chk({vecs[i].name, "_result_held"}, result, vecs[i].exp_val);
      end
    end

    // SUB operand encoding, with a second start while busy that must be ignored.
    alu_lat = 2;
    run_expr(3'd1, 1'b1, ok);
    chk("sub_poke_completed", ok, 1);
    chk("sub_alu_op", cap_op, 3'b011);
    chk("sub_operand_a", cap_a, 32'h40A00000);
    chk("sub_operand_b", cap_b, 32'hC0400000);
    chk("sub_poke_result", result, 32'h40000000);
    chk("sub_poke_no_err", err_cnt - er0, 0);
    chk("sub_poke_rv", rv_cnt - rv0, 1);

    // Reset during ALU_WAIT.
    alu_lat = 20;
    rv0 = rv_cnt; er0 = err_cnt; as0 = as_cnt; dn0 = done_cnt;
    @(negedge clock); expr_sel = 3'd0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (as_cnt == as0 && n < 200) begin @(negedge clock); n++; end
    chk("midrst_alu_issued", as_cnt - as0, 1);
    chk("midrst_in_alu_wait", dbg_state, 4'd6);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", dbg_state, 0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    chk("midrst_late_done_seen", done_cnt - dn0, 1);
    chk("midrst_no_rv", rv_cnt - rv0, 0);
    chk("midrst_no_err", err_cnt - er0, 0);
    chk("midrst_idle", dbg_state, 0);

    // Fresh evaluation after the aborted one.
    alu_lat = 1;
    run_expr(3'd0, 1'b0, ok);
    chk("fresh_completed", ok, 1);
    chk("fresh_result", result, 32'h40C00000);
    chk("fresh_rv", rv_cnt - rv0, 1);
    chk("fresh_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
